// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state codes
// and the helper that sizes bit counters from an operand width.
package serial_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_DONE  = ST_DONE
    } state_t;

    // A counter that must be able to hold the value `width` needs this many bits.
    function automatic int cntWidth(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/fs1.sv
// 1-bit full subtractor cell: d = x - y - bi, with the borrow out of the cell.
module fs1 (
    output logic d,
    output logic bo,
    input  logic x,
    input  logic y,
    input  logic bi
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_sub4.sv
// Bit-serial subtractor: d = a - b - bi computed LSB first through a single
// fs1 cell, one bit per clock, with the final borrow reported on bo.
module serial_sub4
    import serial_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bo
);

    localparam int            CW   = cntWidth(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_aSh;
    logic [WIDTH-1:0] r_bSh;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_d;
    logic             r_bo;
    logic             w_diff;
    logic             w_bout;
    logic             w_accept;
    logic             w_last;

    fs1 u_fs1 (
        .d  (w_diff),
        .bo (w_bout),
        .x  (r_aSh[0]),
        .y  (r_bSh[0]),
        .bi (r_br)
    );

    // A new request is taken from IDLE or DONE, so results can run back to back.
    assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_last   = (r_state == S_SHIFT) && (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_SHIFT;
            S_SHIFT: if (w_last) w_next = S_DONE;
            S_DONE:  w_next = start ? S_SHIFT : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Difference bits enter at the MSB so the LSB lands in d[0] after WIDTH shifts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_aSh <= '0;
            r_bSh <= '0;
            r_br  <= 1'b0;
            r_cnt <= '0;
            r_d   <= '0;
            r_bo  <= 1'b0;
        end else if (w_accept) begin
            r_aSh <= a;
            r_bSh <= b;
            r_br  <= bi;
            r_cnt <= '0;
            r_d   <= '0;
            r_bo  <= 1'b0;
        end else if (r_state == S_SHIFT) begin
            r_aSh <= r_aSh >> 1;
            r_bSh <= r_bSh >> 1;
            r_br  <= w_bout;
            r_cnt <= r_cnt + CW'(1);
            r_d   <= {w_diff, r_d[WIDTH-1:1]};
            if (w_last) begin
                r_bo <= w_bout;
            end
        end
    end

    assign busy = (r_state == S_SHIFT);
    assign done = (r_state == S_DONE);
    assign d    = r_d;
    assign bo   = r_bo;

endmodule

// File: tb/tb_serial_sub4.sv
// Random and directed bench for serial_sub4: expected results come from plain
// integer subtraction and are matched against each done pulse in order.
module tb_serial_sub4;

    localparam int WIDTH = 4;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             bi;
        logic [WIDTH-1:0] d;
        logic             bo;
        int               doneCyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             bi = 1'b0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bo;

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   busyRun = 0;
    exp_t q[$];

    serial_sub4 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bi    (bi),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bo    (bo)
    );

    always #5 clk = ~clk;

    // Edge counter: the value seen at a negedge names the edge just taken.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Reference: unsigned a - b - bi, wrapped to WIDTH bits; borrow when a < b + bi.
    function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                   input logic biv, input int acceptCyc);
        exp_t e;
        int   diff;
        diff      = int'(av) - int'(bv) - int'(biv);
        e.a       = av;
        e.b       = bv;
        e.bi      = biv;
        e.d       = WIDTH'(diff);
        e.bo      = (int'(av) < int'(bv) + int'(biv));
        e.doneCyc = acceptCyc + WIDTH;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busyRun = 0;
        end else begin
            if (busy) busyRun++;
            if (done) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_done: got d=%0d bo=%0d, expected no pulse", d, bo);
                end else begin
                    e = q.pop_front();
                    $display("[TB] bi=%0d a=%2d b=%2d d=%2d bo=%0d", e.bi, e.a, e.b, d, bo);
                    checkOutput("d", int'(d), int'(e.d));
                    checkOutput("bo", int'(bo), int'(e.bo));
                    checkOutput("done_cycle", cyc, e.doneCyc);
                    checkOutput("busy_cycles", busyRun, WIDTH);
                    checkOutput("busy_with_done", int'(busy), 0);
                end
                busyRun = 0;
            end
        end
    end

    task automatic waitDrain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL drain_timeout: got %0d pending results, expected 0", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic biv);
        waitDrain();
        a     = av;
        b     = bv;
        bi    = biv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        q.push_back(model(av, bv, biv, cyc));
        a = ~av;
        b = ~bv;
        bi = ~biv;
    endtask

    initial begin
        int k;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_d", int'(d), 0);
        checkOutput("reset_bo", int'(bo), 0);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(4'd9, 4'd3, 1'b0);
        applyStimulus(4'd3, 4'd9, 1'b0);
        applyStimulus(4'd0, 4'd0, 1'b1);
        applyStimulus(4'd15, 4'd15, 1'b1);
        applyStimulus(4'd8, 4'd7, 1'b1);
        waitDrain();

        // Start held high: accepts every WIDTH+1 edges; operand changes mid-shift must not leak in.
        a = 4'd5;
        b = 4'd2;
        bi = 1'b0;
        start = 1'b1;
        @(negedge clk);
        k = cyc;
        for (int i = 0; i < 3; i++) q.push_back(model(4'd5, 4'd2, 1'b0, k + i * (WIDTH + 1)));
        for (int i = 1; i <= 2 * (WIDTH + 1); i++) begin
            @(negedge clk);
            if (i % (WIDTH + 1) == 1) begin
                a = 4'd15;
                b = 4'd0;
                bi = 1'b1;
            end else if (i % (WIDTH + 1) == 3) begin
                a = 4'd5;
                b = 4'd2;
                bi = 1'b0;
            end
        end
        start = 1'b0;
        waitDrain();

        // Reset two cycles into an operation discards it with no later done pulse.
        a = 4'd12;
        b = 4'd1;
        bi = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_done", int'(done), 0);
        checkOutput("abort_d", int'(d), 0);
        checkOutput("abort_bo", int'(bo), 0);
        rst = 1'b0;
        repeat (2 * WIDTH + 2) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
        end
        waitDrain();
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
